// File: rtl/omok_turn_controller_if.sv
// omok_turn_controller_if: buttons, board port, scan port and
// game status between the turn controller and its neighbours.
interface omok_turn_controller_if;
    logic       put;
    logic       undo;
    logic [7:0] cursor_pos;
    logic [7:0] rd_addr;
    logic [1:0] rd_data;
    logic       wr_en;
    logic [7:0] wr_addr;
    logic [1:0] wr_data;
    logic       clear_board;
    logic       scan_start;
    logic       scan_done;
    logic       black_win;
    logic       white_win;
    logic       turn;
    logic [7:0] move_count;
    logic       busy;
    logic       reject;
    logic       game_over;
    logic [1:0] winner;

    modport master (
        input  put, undo, cursor_pos, rd_data,
        input  scan_done, black_win, white_win,
        output rd_addr, wr_en, wr_addr, wr_data,
        output clear_board, scan_start, turn,
        output move_count, busy, reject,
        output game_over, winner
    );

    modport slave (
        output put, undo, cursor_pos, rd_data,
        output scan_done, black_win, white_win,
        input  rd_addr, wr_en, wr_addr, wr_data,
        input  clear_board, scan_start, turn,
        input  move_count, busy, reject,
        input  game_over, winner
    );
endinterface

// File: rtl/omok_turn_controller.sv
// omok_turn_controller: validates and commits moves, runs the win
// scan, keeps an undo stack and clears the board after a game.
module omok_turn_controller #(
    parameter int          CELLS        = 100,
    parameter int          HIST_DEPTH   = 100,
    parameter int          SCAN_TIMEOUT = 255,
    parameter logic [15:0] OVER_HOLD    = 16'd50000
) (
    input logic clk,
    input logic rst,
    omok_turn_controller_if.master bus
);
    localparam int SPW = $clog2(HIST_DEPTH + 1);
    localparam int HAW = $clog2(HIST_DEPTH);

    typedef enum logic [3:0] {
        S_IDLE, S_CHECK, S_WRITE, S_LAUNCH, S_SCAN,
        S_UNDO1, S_UNDO2, S_OVER, S_CLEAR
    } state_t;

    state_t       state_q, state_d;
    logic         turn_q, turn_d;
    logic [7:0]   move_count_q, move_count_d;
    logic [SPW-1:0] sp_q, sp_d;
    logic [1:0]   winner_q, winner_d;
    logic [7:0]   pos_q, pos_d;
    logic [7:0]   pop_q, pop_d;
    logic [15:0]  cnt_q, cnt_d;
    logic         reject_q, reject_d;
    logic         put_q, undo_q;
    logic         push;
    logic [7:0]   hist_q [HIST_DEPTH];

    logic put_rise;
    logic undo_rise;
    assign put_rise  = bus.put & ~put_q;
    assign undo_rise = bus.undo & ~undo_q;

    // State and datapath registers, all cleared by reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            turn_q       <= 1'b0;
            move_count_q <= 8'd0;
            sp_q         <= '0;
            winner_q     <= 2'b00;
            pos_q        <= 8'd0;
            pop_q        <= 8'd0;
            cnt_q        <= 16'd0;
            reject_q     <= 1'b0;
            put_q        <= 1'b0;
            undo_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            turn_q       <= turn_d;
            move_count_q <= move_count_d;
            sp_q         <= sp_d;
            winner_q     <= winner_d;
            pos_q        <= pos_d;
            pop_q        <= pop_d;
            cnt_q        <= cnt_d;
            reject_q     <= reject_d;
            put_q        <= bus.put;
            undo_q       <= bus.undo;
        end
    end

    // Move-history stack; contents need no reset, only the pointer.
    always_ff @(posedge clk) begin
        if (push && sp_q < SPW'(HIST_DEPTH))
            hist_q[HAW'(sp_q)] <= pos_q;
    end

    // Next-state and register updates for the game sequencer.
    always_comb begin
        state_d      = state_q;
        turn_d       = turn_q;
        move_count_d = move_count_q;
        sp_d         = sp_q;
        winner_d     = winner_q;
        pos_d        = pos_q;
        pop_d        = pop_q;
        cnt_d        = cnt_q;
        reject_d     = 1'b0;
        push         = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (put_rise) begin
                    if (bus.cursor_pos >= 8'(CELLS)) begin
                        reject_d = 1'b1;
                    end else begin
                        pos_d   = bus.cursor_pos;
                        state_d = S_CHECK;
                    end
                end else if (undo_rise) begin
                    if (move_count_q == 8'd0) reject_d = 1'b1;
                    else state_d = S_UNDO1;
                end
            end
            S_CHECK: begin
                if (bus.rd_data != 2'b00) begin
                    reject_d = 1'b1;
                    state_d  = S_IDLE;
                end else begin
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                push = 1'b1;
                if (sp_q < SPW'(HIST_DEPTH)) sp_d = sp_q + 1'b1;
                if (move_count_q < 8'(CELLS))
                    move_count_d = move_count_q + 8'd1;
                state_d = S_LAUNCH;
            end
            S_LAUNCH: begin
                cnt_d   = 16'd0;
                state_d = S_SCAN;
            end
            S_SCAN: begin
                if (bus.scan_done) begin
                    cnt_d = 16'd0;
                    if (bus.black_win) begin
                        winner_d = 2'b01;
                        state_d  = S_OVER;
                    end else if (bus.white_win) begin
                        winner_d = 2'b10;
                        state_d  = S_OVER;
                    end else if (move_count_q == 8'(CELLS)) begin
                        winner_d = 2'b11;
                        state_d  = S_OVER;
                    end else begin
                        turn_d  = ~turn_q;
                        state_d = S_IDLE;
                    end
                end else if (cnt_q == 16'(SCAN_TIMEOUT - 1)) begin
                    reject_d = 1'b1;
                    turn_d   = ~turn_q;
                    state_d  = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_UNDO1: begin
                sp_d    = sp_q - 1'b1;
                pop_d   = hist_q[HAW'(sp_q - 1'b1)];
                state_d = S_UNDO2;
            end
            S_UNDO2: begin
                if (move_count_q != 8'd0)
                    move_count_d = move_count_q - 8'd1;
                turn_d  = ~turn_q;
                state_d = S_IDLE;
            end
            S_OVER: begin
                if (put_rise || cnt_q == OVER_HOLD - 16'd1)
                    state_d = S_CLEAR;
                else
                    cnt_d = cnt_q + 16'd1;
            end
            S_CLEAR: begin
                turn_d       = 1'b0;
                move_count_d = 8'd0;
                sp_d         = '0;
                winner_d     = 2'b00;
                state_d      = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.rd_addr     = pos_q;
    assign bus.wr_en       = (state_q == S_WRITE) || (state_q == S_UNDO2);
    assign bus.wr_addr     = (state_q == S_WRITE) ? pos_q : pop_q;
    assign bus.wr_data     = (state_q == S_WRITE) ? {1'b1, turn_q} : 2'b00;
    assign bus.clear_board = (state_q == S_CLEAR);
    assign bus.scan_start  = (state_q == S_LAUNCH);
    assign bus.turn        = turn_q;
    assign bus.move_count  = move_count_q;
    assign bus.busy        = (state_q != S_IDLE) && (state_q != S_OVER);
    assign bus.reject      = reject_q;
    assign bus.game_over   = (state_q == S_OVER);
    assign bus.winner      = winner_q;
endmodule

// File: tb/tb_omok_turn_controller.sv
// tb_omok_turn_controller: directed moves, undo, rejects, win,
// game-over clear, scan timeout and asynchronous reset.
module tb_omok_turn_controller;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   total = 0;
    int   bad = 0;
    logic [1:0] board [256];

    omok_turn_controller_if bus ();

    omok_turn_controller #(.OVER_HOLD(16'd40)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    assign bus.rd_data = board[bus.rd_addr];

    // Board store model: written by wr_en, zeroed by clear or reset.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 256; i++) board[i] <= 2'b00;
        end else if (bus.clear_board) begin
            for (int i = 0; i < 256; i++) board[i] <= 2'b00;
        end else if (bus.wr_en) begin
            board[bus.wr_addr] <= bus.wr_data;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs,
                         input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic place(input logic [7:0] pos, input logic [1:0] color,
                         input logic bw, input logic ww);
        bus.cursor_pos = pos;
        bus.put = 1'b1;
        tick();
        check("chk_rd_addr", 16'(bus.rd_addr), 16'(pos));
        check("chk_busy", 16'(bus.busy), 16'd1);
        tick();
        check("wr_en", 16'(bus.wr_en), 16'd1);
        check("wr_addr", 16'(bus.wr_addr), 16'(pos));
        check("wr_data", 16'(bus.wr_data), 16'(color));
        tick();
        check("scan_start", 16'(bus.scan_start), 16'd1);
        check("no_wr_in_launch", 16'(bus.wr_en), 16'd0);
        bus.scan_done = 1'b1;
        bus.black_win = bw;
        bus.white_win = ww;
        tick();
        tick();
        bus.scan_done = 1'b0;
        bus.black_win = 1'b0;
        bus.white_win = 1'b0;
        bus.put = 1'b0;
        tick();
    endtask

    task automatic do_undo(input logic [7:0] addr);
        bus.undo = 1'b1;
        tick();
        check("undo1_busy", 16'(bus.busy), 16'd1);
        tick();
        check("undo_wr_en", 16'(bus.wr_en), 16'd1);
        check("undo_wr_addr", 16'(bus.wr_addr), 16'(addr));
        check("undo_wr_data", 16'(bus.wr_data), 16'd0);
        tick();
        bus.undo = 1'b0;
        tick();
    endtask

    initial begin
        int n;
        int wr_pulses;
        int clr_pulses;
        bus.put = 1'b0;
        bus.undo = 1'b0;
        bus.cursor_pos = 8'd0;
        bus.scan_done = 1'b0;
        bus.black_win = 1'b0;
        bus.white_win = 1'b0;
        tick();
        tick();
        check("rst_turn", 16'(bus.turn), 16'd0);
        check("rst_count", 16'(bus.move_count), 16'd0);
        check("rst_busy", 16'(bus.busy), 16'd0);
        check("rst_over", 16'(bus.game_over), 16'd0);
        check("rst_winner", 16'(bus.winner), 16'd0);
        check("rst_strobes",
              16'({bus.wr_en, bus.clear_board, bus.scan_start, bus.reject}),
              16'd0);
        rst = 1'b1;
        tick();

        place(8'd44, 2'b10, 1'b0, 1'b0);
        check("m1_turn", 16'(bus.turn), 16'd1);
        check("m1_count", 16'(bus.move_count), 16'd1);

        bus.cursor_pos = 8'd44;
        bus.put = 1'b1;
        tick();
        check("occ_no_wr", 16'(bus.wr_en), 16'd0);
        tick();
        check("occ_reject", 16'(bus.reject), 16'd1);
        check("occ_turn", 16'(bus.turn), 16'd1);
        bus.put = 1'b0;
        tick();
        check("reject_one_cycle", 16'(bus.reject), 16'd0);

        place(8'd45, 2'b11, 1'b0, 1'b0);
        check("m2_count", 16'(bus.move_count), 16'd2);
        do_undo(8'd45);
        check("u1_count", 16'(bus.move_count), 16'd1);
        check("u1_turn", 16'(bus.turn), 16'd1);
        do_undo(8'd44);
        check("u2_count", 16'(bus.move_count), 16'd0);
        check("u2_turn", 16'(bus.turn), 16'd0);
        bus.undo = 1'b1;
        tick();
        check("u3_reject", 16'(bus.reject), 16'd1);
        check("u3_busy", 16'(bus.busy), 16'd0);
        bus.undo = 1'b0;
        tick();

        bus.cursor_pos = 8'd100;
        bus.put = 1'b1;
        tick();
        check("oob_reject", 16'(bus.reject), 16'd1);
        check("oob_busy", 16'(bus.busy), 16'd0);
        bus.put = 1'b0;
        tick();

        bus.cursor_pos = 8'd7;
        bus.put = 1'b1;
        bus.scan_done = 1'b1;
        wr_pulses = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (bus.wr_en) wr_pulses++;
        end
        bus.put = 1'b0;
        bus.scan_done = 1'b0;
        tick();
        check("hold_one_move", 16'(wr_pulses), 16'd1);
        check("hold_count", 16'(bus.move_count), 16'd1);
        check("hold_turn", 16'(bus.turn), 16'd1);

        for (int k = 0; k < 4; k++) begin
            place(8'(90 + k), 2'b11, 1'b0, 1'b0);
            place(8'(k), 2'b10, 1'b0, 1'b0);
        end
        place(8'd94, 2'b11, 1'b0, 1'b0);
        place(8'd4, 2'b10, 1'b1, 1'b0);
        check("win_over", 16'(bus.game_over), 16'd1);
        check("win_winner", 16'(bus.winner), 16'b01);
        check("win_busy", 16'(bus.busy), 16'd0);
        check("win_count", 16'(bus.move_count), 16'd11);
        bus.undo = 1'b1;
        tick();
        check("over_undo_no_reject", 16'(bus.reject), 16'd0);
        check("over_undo_held", 16'(bus.game_over), 16'd1);
        bus.undo = 1'b0;
        clr_pulses = 0;
        n = 0;
        while (bus.game_over && n < 100) begin
            tick();
            n++;
            if (bus.clear_board) clr_pulses++;
        end
        check("hold_expired", 16'(bus.game_over), 16'd0);
        tick();
        if (bus.clear_board) clr_pulses++;
        check("one_clear", 16'(clr_pulses), 16'd1);
        check("clr_turn", 16'(bus.turn), 16'd0);
        check("clr_count", 16'(bus.move_count), 16'd0);
        check("clr_winner", 16'(bus.winner), 16'd0);
        check("clr_board44", 16'(board[44]), 16'd0);

        place(8'd50, 2'b10, 1'b0, 1'b0);
        place(8'd60, 2'b11, 1'b0, 1'b1);
        check("wwin_winner", 16'(bus.winner), 16'b10);
        check("wwin_over", 16'(bus.game_over), 16'd1);
        bus.put = 1'b1;
        tick();
        check("put_clear", 16'(bus.clear_board), 16'd1);
        check("put_clear_no_wr", 16'(bus.wr_en), 16'd0);
        tick();
        check("put_clear_done", 16'(bus.clear_board), 16'd0);
        check("put_clear_count", 16'(bus.move_count), 16'd0);
        check("put_clear_over", 16'(bus.game_over), 16'd0);
        bus.put = 1'b0;
        tick();

        bus.cursor_pos = 8'd33;
        bus.put = 1'b1;
        tick();
        tick();
        tick();
        check("to_scan_start", 16'(bus.scan_start), 16'd1);
        bus.put = 1'b0;
        n = 0;
        while (!bus.reject && n < 300) begin
            tick();
            n++;
        end
        check("to_reject", 16'(bus.reject), 16'd1);
        check("to_window", 16'(n >= 255 && n <= 257), 16'd1);
        check("to_turn", 16'(bus.turn), 16'd1);
        check("to_count", 16'(bus.move_count), 16'd1);
        check("to_idle", 16'(bus.busy), 16'd0);
        tick();

        bus.cursor_pos = 8'd34;
        bus.put = 1'b1;
        tick();
        tick();
        tick();
        tick();
        check("mid_scan_busy", 16'(bus.busy), 16'd1);
        rst = 1'b0;
        #1;
        check("arst_busy", 16'(bus.busy), 16'd0);
        check("arst_turn", 16'(bus.turn), 16'd0);
        check("arst_count", 16'(bus.move_count), 16'd0);
        check("arst_strobes",
              16'({bus.wr_en, bus.clear_board, bus.scan_start, bus.reject}),
              16'd0);
        check("arst_over", 16'({bus.game_over, bus.winner}), 16'd0);
        bus.put = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        check("post_rst_idle", 16'(bus.busy), 16'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
